// File: rtl/cache_line_bridge.sv
// rtl/cache_line_bridge.sv - 128-bit cache line port to four 32-bit Avalon-MM word transfers
//
// Accepts one line fill or line writeback at a time from the L1 cache. The line is
// moved as four word transfers at {base[31:4], word[1:0], 2'b00}. Read returns
// arrive in issue order, possibly overlapping the remaining issues, and are gathered
// into one line that is presented with a single-cycle valid pulse.
//
// Ports:
//   clk, rst            - clock; asynchronous active-high reset
//   s_addr              - line address (bits [3:0] ignored)
//   s_writedata         - line to write back, word i at [32i+31:32i]
//   s_read, s_write     - line fill / writeback request (write wins if both)
//   s_readdata          - last gathered line, held until the next fill completes
//   s_readdata_valid    - one-cycle pulse when s_readdata is updated
//   s_waitrequest       - high while busy or in reset
//   mem_addr            - word address of the current command
//   mem_writedata       - word being written
//   mem_read, mem_write - word command strobes, held while mem_waitrequest is high
//   mem_readdata        - returned word
//   mem_readdata_valid  - mem_readdata valid
//   mem_waitrequest     - current command not accepted this cycle

module cache_line_bridge (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  s_addr,
    input  logic [127:0] s_writedata,
    input  logic         s_read,
    input  logic         s_write,
    output logic [127:0] s_readdata,
    output logic         s_readdata_valid,
    output logic         s_waitrequest,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_writedata,
    output logic         mem_read,
    output logic         mem_write,
    input  logic [31:0]  mem_readdata,
    input  logic         mem_readdata_valid,
    input  logic         mem_waitrequest
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR       = 2'd1,
        RD_ISSUE = 2'd2,
        RD_WAIT  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     icnt;
    logic [2:0]     rcnt;
    logic [27:0]    base;
    logic [127:0]   wline;
    logic [127:0]   rline;
    logic [127:0]   fill_line;
    logic           accept;
    logic           issue;
    logic           ret;
    logic           last_issue;
    logic           last_ret;

    // Line offset bits are don't-care; reduce them so they are visibly consumed.
    logic           unused_addr_lsbs;
    assign unused_addr_lsbs = ^s_addr[3:0];

    assign accept     = (state == IDLE) && (s_read || s_write);
    assign issue      = (mem_read || mem_write) && !mem_waitrequest;
    // Returns only count while a fill is in flight; anything else is a stray.
    assign ret        = mem_readdata_valid && ((state == RD_ISSUE) || (state == RD_WAIT));
    assign last_issue = issue && (icnt == 2'd3);
    assign last_ret   = ret && (rcnt == 3'd3);

    // Current line buffer with the arriving word merged into its slot; used both to
    // update the buffer and to publish the complete line on the final return.
    always_comb begin
        fill_line = rline;
        fill_line[{rcnt[1:0], 5'b00000} +: 32] = mem_readdata;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (s_write) begin
                    state_nxt = WR;
                end else if (s_read) begin
                    state_nxt = RD_ISSUE;
                end
            end
            WR: begin
                if (last_issue) begin
                    state_nxt = IDLE;
                end
            end
            RD_ISSUE: begin
                // A zero-latency fourth return can coincide with the fourth issue.
                if (last_ret) begin
                    state_nxt = IDLE;
                end else if (last_issue) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (last_ret) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs. Command fields depend only on registered state, so they stay
    // stable for as long as mem_waitrequest stalls the command.
    always_comb begin
        s_waitrequest = rst || (state != IDLE);
        mem_read      = (state == RD_ISSUE);
        mem_write     = (state == WR);
        mem_addr      = {base, icnt, 2'b00};
        mem_writedata = wline[{icnt, 5'b00000} +: 32];
    end

    // Datapath and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icnt             <= 2'd0;
            rcnt             <= 3'd0;
            base             <= 28'd0;
            wline            <= 128'd0;
            rline            <= 128'd0;
            s_readdata       <= 128'd0;
            s_readdata_valid <= 1'b0;
        end else begin
            s_readdata_valid <= 1'b0;
            if (accept) begin
                base <= s_addr[31:4];
                icnt <= 2'd0;
                rcnt <= 3'd0;
                if (s_write) begin
                    wline <= s_writedata;
                end
            end
            if (issue) begin
                icnt <= icnt + 2'd1;
            end
            if (ret) begin
                rline <= fill_line;
                rcnt  <= rcnt + 3'd1;
                if (last_ret) begin
                    rcnt             <= 3'd0;
                    s_readdata       <= fill_line;
                    s_readdata_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_line_bridge.sv
// tb/tb_cache_line_bridge.sv - directed scoreboard bench for cache_line_bridge

module tb_cache_line_bridge;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  s_addr = '0;
    logic [127:0] s_writedata = '0;
    logic         s_read = 1'b0;
    logic         s_write = 1'b0;
    logic [127:0] s_readdata;
    logic         s_readdata_valid;
    logic         s_waitrequest;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_writedata;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_readdata = '0;
    logic         mem_readdata_valid = 1'b0;
    logic         mem_waitrequest = 1'b0;

    cache_line_bridge dut (
        .clk                (clk),
        .rst                (rst),
        .s_addr             (s_addr),
        .s_writedata        (s_writedata),
        .s_read             (s_read),
        .s_write            (s_write),
        .s_readdata         (s_readdata),
        .s_readdata_valid   (s_readdata_valid),
        .s_waitrequest      (s_waitrequest),
        .mem_addr           (mem_addr),
        .mem_writedata      (mem_writedata),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_readdata       (mem_readdata),
        .mem_readdata_valid (mem_readdata_valid),
        .mem_waitrequest    (mem_waitrequest)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    cmd_t         exp_cmd[$];
    logic [127:0] exp_line[$];
    ret_t         ret_q[$];

    int          lat = 2;
    int          stall_word = 0;
    int          stall_left = 0;
    logic [31:0] rd_val = 32'h0;
    int          issue_cnt = 0;
    int          valid_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    cmd_t mc;
    ret_t mr;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model and monitor, evaluated mid-cycle. A command seen here is issued at
    // the next rising edge; its return is driven lat cycles after that sample so that
    // it is captured lat edges after the issue edge.
    always @(negedge clk) begin
        mem_readdata_valid = 1'b0;
        mem_readdata       = 32'h0;
        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            mr = ret_q.pop_front();
            mem_readdata_valid = 1'b1;
            mem_readdata       = mr.data;
        end

        mem_waitrequest = 1'b0;
        if (mem_write && !rst && stall_left > 0 && int'(mem_addr[3:2]) == stall_word) begin
            mem_waitrequest = 1'b1;
            stall_left--;
            if (exp_cmd.size() > 0) begin
                chk("stall_addr_held", mem_addr, exp_cmd[0].addr);
                chk("stall_data_held", mem_writedata, exp_cmd[0].data);
            end
        end

        if ((mem_write || mem_read) && !mem_waitrequest && !rst) begin
            issue_cnt++;
            chk("cmd_one_hot", mem_read & mem_write, 1'b0);
            chk("cmd_expected", exp_cmd.size() != 0, 1'b1);
            if (exp_cmd.size() != 0) begin
                mc = exp_cmd.pop_front();
                chk("cmd_kind", mem_write, mc.we);
                chk("cmd_addr", mem_addr, mc.addr);
                if (mc.we) chk("cmd_wdata", mem_writedata, mc.data);
            end
            if (mem_read) begin
                mr.due  = cyc + lat;
                mr.data = rd_val + 32'(mem_addr[3:2]);
                ret_q.push_back(mr);
            end
        end

        if (s_readdata_valid) begin
            valid_cnt++;
            chk("rvalid_expected", exp_line.size() != 0, 1'b1);
            if (exp_line.size() != 0) chk("line_data", s_readdata, exp_line.pop_front());
        end
    end

    // Present a request mid-cycle; returns just after the accepting edge T with t=T.
    task automatic issue_req(input bit wr, input bit rd, input logic [31:0] addr,
                             input logic [127:0] data, input bit want_line, output int t);
        cmd_t        c;
        logic [31:0] b;
        b = {addr[31:4], 4'h0};
        for (int i = 0; i < 4; i++) begin
            c.we   = wr;
            c.addr = b | 32'(i << 2);
            c.data = data[32*i +: 32];
            exp_cmd.push_back(c);
        end
        if (!wr && want_line)
            exp_line.push_back({rd_val + 32'd3, rd_val + 32'd2, rd_val + 32'd1, rd_val});
        s_addr      = addr;
        s_writedata = data;
        s_write     = wr;
        s_read      = rd;
        chk("accept_ready", s_waitrequest, 1'b0);
        @(posedge clk);
        #1;
        t = cyc;
        chk("busy_after_accept", s_waitrequest, 1'b1);
        s_read  = 1'b0;
        s_write = 1'b0;
    endtask

    task automatic wait_idle(input int t, input int exp_d, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (s_waitrequest && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, cyc - t, exp_d);
    endtask

    task automatic wait_valid(input int t, input int exp_d, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!s_readdata_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, cyc - t, exp_d);
    endtask

    initial begin
        int t;
        int t2;
        int v0;
        int ic0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_waitreq", s_waitrequest, 1'b1);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_writedata, 32'h0);
        chk("rst_rdata", s_readdata, 128'h0);
        chk("rst_rvalid", s_readdata_valid, 1'b0);
        rst = 1'b0;
        #1;
        chk("idle_waitreq", s_waitrequest, 1'b0);
        @(negedge clk);

        // Write line, no waits
        v0 = valid_cnt; ic0 = issue_cnt;
        issue_req(1'b1, 1'b0, 32'h0000_1238,
                  128'h44444444_33333333_22222222_11111111, 1'b0, t);
        wait_idle(t, 4, "wr_done_time");
        chk("wr_issue_count", issue_cnt - ic0, 4);
        chk("wr_no_rvalid", valid_cnt - v0, 0);

        // Read line, L=2
        lat = 2; rd_val = 32'h0000_00A0;
        issue_req(1'b0, 1'b1, 32'h0000_0040, 128'h0, 1'b1, t);
        wait_valid(t, 6, "rd_valid_time");
        chk("rd_line", s_readdata, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("rd_idle_in_valid_cycle", s_waitrequest, 1'b0);
        @(negedge clk);
        chk("rd_valid_pulse", s_readdata_valid, 1'b0);

        // Write with 3 wait states on word 1
        stall_word = 1; stall_left = 3; ic0 = issue_cnt;
        issue_req(1'b1, 1'b0, 32'h0000_2000,
                  128'hDEAD0003_BEEF0002_CAFE0001_F00D0000, 1'b0, t);
        wait_idle(t, 7, "wr_stall_done_time");
        chk("wr_stall_issue_count", issue_cnt - ic0, 4);
        chk("wr_stall_consumed", stall_left, 0);

        // Read and write together: only the write happens
        v0 = valid_cnt; ic0 = issue_cnt;
        issue_req(1'b1, 1'b1, 32'h0000_3004,
                  128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D, 1'b0, t);
        wait_idle(t, 4, "collide_done_time");
        chk("collide_issue_count", issue_cnt - ic0, 4);
        chk("collide_no_rvalid", valid_cnt - v0, 0);

        // Back-to-back reads: second accepted in the first one's valid cycle
        lat = 1; rd_val = 32'h0000_00B0;
        issue_req(1'b0, 1'b1, 32'h0000_5010, 128'h0, 1'b1, t);
        wait_valid(t, 5, "b2b_first_valid_time");
        rd_val = 32'h0000_00C0;
        issue_req(1'b0, 1'b1, 32'h0000_6020, 128'h0, 1'b1, t2);
        chk("b2b_accept_edge", t2 - t, 6);
        chk("b2b_valid_pulse", s_readdata_valid, 1'b0);
        wait_valid(t2, 5, "b2b_second_valid_time");
        chk("b2b_second_line", s_readdata, 128'h000000C3_000000C2_000000C1_000000C0);

        // Reset after two reads issued
        lat = 4; rd_val = 32'h0000_00D0;
        repeat (2) @(negedge clk);
        v0 = valid_cnt; ic0 = issue_cnt;
        issue_req(1'b0, 1'b1, 32'h0000_7000, 128'h0, 1'b0, t);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_rd_issued", issue_cnt - ic0, 2);
        rst = 1'b1;
        #1;
        chk("midrst_waitreq", s_waitrequest, 1'b1);
        chk("midrst_mem_read", mem_read, 1'b0);
        chk("midrst_mem_write", mem_write, 1'b0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_mem_wdata", mem_writedata, 32'h0);
        chk("midrst_rdata", s_readdata, 128'h0);
        chk("midrst_rvalid", s_readdata_valid, 1'b0);
        chk("midrst_pending_cmds", exp_cmd.size(), 2);
        exp_cmd.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("stray_no_rvalid", valid_cnt - v0, 0);
        lat = 2; rd_val = 32'h0000_00E0;
        issue_req(1'b0, 1'b1, 32'h0000_7000, 128'h0, 1'b1, t);
        wait_valid(t, 6, "post_rst_valid_time");
        chk("post_rst_line", s_readdata, 128'h000000E3_000000E2_000000E1_000000E0);
        repeat (3) @(negedge clk);
        chk("leftover_cmds", exp_cmd.size(), 0);
        chk("leftover_lines", exp_line.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cache_line_bridge.md
# cache_line_bridge

Memory-side adapter directly downstream of the L1 cache's 128-bit line port. It accepts one line read (fill) or line write (writeback) at a time from the cache and performs it as a sequence of four 32-bit Avalon-MM transfers to the memory/interconnect. Read data words are returned pipelined and gathered into one 128-bit line.

## Interface
- No parameters. Line size is fixed at 4 × 32-bit words.

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_addr`  in  32  line address from the cache; bits [3:0] are ignored.
- `s_writedata`  in  128  line to write; word i is bits [32i+31:32i].
- `s_read`  in  1  line fill request.
- `s_write`  in  1  line writeback request.
- `s_readdata`  out  128  gathered line; word i is bits [32i+31:32i].
- `s_readdata_valid`  out  1  one-cycle pulse; `s_readdata` is valid.
- `s_waitrequest`  out  1  high means the cache request is not accepted.
- `mem_addr`  out  32  word address, {base[31:4], i[1:0], 2'b00}.
- `mem_writedata`  out  32  write word.
- `mem_read`  out  1  word read request.
- `mem_write`  out  1  word write request.
- `mem_readdata`  in  32  returned word.
- `mem_readdata_valid`  in  1  `mem_readdata` is valid; words return in issue order.
- `mem_waitrequest`  in  1  high means the current memory command is not accepted.

## Operation
- **States:**
  - `IDLE`: the only state that accepts a request.
  - `WR`: issuing the four write words.
  - `RD_ISSUE`: issuing the four read commands while collecting returns.
  - `RD_WAIT`: all reads issued; collecting the remaining returns.
- **s_waitrequest:** combinational, low only in `IDLE`.
- **Acceptance:** a request is accepted on an edge where (`s_read` | `s_write`) is high and `s_waitrequest` is low.
  - On acceptance, latch base = {s_addr[31:4],4'b0} and, for writes, `s_writedata`.
  - If `s_read` and `s_write` are both high, the write is taken and the read is ignored. The cache must re-present it.
- **Issue counter:** `icnt[1:0]`. `mem_addr` = base | icnt<<2.
  - A word is issued on an edge with `mem_read`/`mem_write` high and `mem_waitrequest` low; `icnt` then increments.
  - While `mem_waitrequest` is high, `mem_addr`, `mem_writedata`, `mem_read` and `mem_write` are held stable.
- **WR:**
  - `mem_write`=1; `mem_writedata` = latched word `icnt`.
  - After word 3 is issued, go to `IDLE`.
  - Writes produce no `s_readdata_valid`.
- **RD_ISSUE:**
  - `mem_read`=1.
  - After word 3 is issued, go to `RD_WAIT`, unless that same edge also completes the fourth return, in which case go to `IDLE`.
- **Return counter:** `rcnt[2:0]`.
  - Counts `mem_readdata_valid` in `RD_ISSUE` and `RD_WAIT`.
  - Each return writes `mem_readdata` into line slot `rcnt[1:0]`.
  - Issue and return may occur on the same edge and are counted independently.
- **Read completion:** on the fourth return, go to `IDLE`.
  - On that edge, register `s_readdata_valid`=1 for exactly one cycle, with `s_readdata` holding the full line.
  - `s_readdata` keeps its value until the next read completes.
- **Stray returns:** `mem_readdata_valid` in `IDLE` or `WR` is ignored.

## Timing
- **Reset values:**
  - State `IDLE`; `icnt`=0, `rcnt`=0.
  - `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_writedata`=0.
  - `s_readdata`=0, `s_readdata_valid`=0.
  - `s_waitrequest`=0 while `rst` is deasserted in `IDLE`; forced high while `rst` is asserted.
- **Reset mid-operation:** the operation is abandoned immediately. Issued words are not retried; late returns are ignored per the stray rule.
- **Write, zero wait states** (accepted at edge T): words 0–3 are issued on edges T+1..T+4. `IDLE` is reached, with `s_waitrequest` low, in the cycle after T+4. The next acceptance is possible at T+5.
- **Read, zero wait states, fixed memory latency L ≥ 1:**
  - Word i is issued at T+1+i and returns at T+1+i+L.
  - `s_readdata_valid` is high in the cycle after edge T+4+L, which is also the first `IDLE` cycle.
  - A new request may be accepted in that same cycle.
- **Wait states:** each `mem_waitrequest` cycle delays the remaining issues by one cycle. No command is dropped or duplicated.
- **Commands per line:** exactly 4 per line, never more.

## Test plan
- **Write line:** write base 0x0000_1238, data 0x44444444_33333333_22222222_11111111, no waits. Expect `mem_write` at addresses 0x1230, 0x1234, 0x1238, 0x123C with data 0x11111111, 0x22222222, 0x33333333, 0x44444444 on edges T+1..T+4. `s_waitrequest` is low again at T+5; `s_readdata_valid` stays 0 throughout.
- **Read line, L=2:** read base 0x0000_0040; memory returns 0xA0, 0xA1, 0xA2, 0xA3. Expect `s_readdata` = 0x000000A3_000000A2_000000A1_000000A0 and a single `s_readdata_valid` pulse in the cycle after edge T+6.
- **Write with wait states:** write with `mem_waitrequest` high for 3 cycles on word 1. Expect address 0x…4 and its data held stable across the stall, 4 total accepted writes, and the operation finishing 3 cycles later than the no-wait case.
- **Collision and back-to-back:** assert `s_read` and `s_write` together → only the write is performed. Then issue a read immediately in the `s_readdata_valid` cycle of a prior read → it is accepted in that cycle.
- **Reset mid-read:** assert `rst` after 2 reads are issued. Expect all outputs at their reset values. Two late `mem_readdata_valid` pulses afterwards produce no `s_readdata_valid`, and a following read completes with correct data.
